// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Optional build macro used by the top: RF_ARB_ZERO_REG_EN (register 0 hardwired zero).
package rf_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    // Requester index: the load path is the default-priority owner of the port.
    typedef enum logic {
        REQ_MEM = 1'b0,
        REQ_ALU = 1'b1
    } req_idx_t;

    typedef logic [3:0] starve_cnt_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic starve_cnt_t sat_inc(input starve_cnt_t value, input starve_cnt_t limit);
        starve_cnt_t result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Saturating count of consecutive cycles the ALU requester lost arbitration.
// force_r1 asserts once the count reaches STARVE_LIMIT (legal 1..15).
module rf_arb_starve_ctr
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        r1_valid,
    input  logic        grant_r0,
    output logic [3:0]  starve_cnt,
    output logic        force_r1
);

    localparam starve_cnt_t LIMIT = starve_cnt_t'(STARVE_LIMIT);

    starve_cnt_t cnt_q;
    starve_cnt_t cnt_d;
    logic        lost;

    // A loss is only a loss if the ALU path was actually waiting.
    assign lost = grant_r0 & r1_valid;

    // Next count: bump on a loss, clear on any other unstalled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!stall) begin
            if (lost) begin
                cnt_d = sat_inc(cnt_q, LIMIT);
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Count register; a stalled cycle holds the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_cnt = cnt_q;
    assign force_r1   = (cnt_q == LIMIT);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Load writeback (r0) has fixed priority; ALU writeback (r1) is forced through
// after STARVE_LIMIT consecutive losses. Accepted writes appear one cycle later
// as a single-cycle strobe.
// Build macro: RF_ARB_ZERO_REG_EN -- when defined, writes to register 0 are
// accepted but never strobed to the register file.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_reg,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_reg,
    input  logic [DATA_W-1:0] r1_data,
    output logic              rf_write_reg,
    output logic [ADDR_W-1:0] rf_dst,
    output logic [DATA_W-1:0] rf_data,
    output logic [3:0]        starve_cnt
);

    logic              force_r1;
    logic              grant_r0;
    logic              grant_r1;
    logic              xfer;
    logic              commit;
    req_idx_t          winner;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;

    rf_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .r1_valid   (r1_valid),
        .grant_r0   (grant_r0),
        .starve_cnt (starve_cnt),
        .force_r1   (force_r1)
    );

    // Grant: nothing under stall, lone requester wins, contention goes to r0 unless r1 is starved.
    always_comb begin
        grant_r0 = 1'b0;
        grant_r1 = 1'b0;
        if (!stall) begin
            if (r0_valid && r1_valid) begin
                if (force_r1) begin
                    grant_r1 = 1'b1;
                end else begin
                    grant_r0 = 1'b1;
                end
            end else if (r0_valid) begin
                grant_r0 = 1'b1;
            end else if (r1_valid) begin
                grant_r1 = 1'b1;
            end
        end
    end

    assign r0_ready = grant_r0;
    assign r1_ready = grant_r1;
    assign xfer     = grant_r0 | grant_r1;
    assign winner   = grant_r1 ? REQ_ALU : REQ_MEM;

    // Steer the winning requester's id and data toward the output stage.
    always_comb begin
        win_reg  = r0_reg;
        win_data = r0_data;
        if (winner == REQ_ALU) begin
            win_reg  = r1_reg;
            win_data = r1_data;
        end
    end

`ifdef RF_ARB_ZERO_REG_EN
    // Register 0 reads as zero, so a write there is swallowed after the handshake.
    assign commit = xfer && (win_reg != '0);
`else
    assign commit = xfer;
`endif

    // Output stage: one-cycle strobe, id/data only move when a write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_reg <= 1'b0;
            rf_dst       <= '0;
            rf_data      <= '0;
        end else begin
            rf_write_reg <= commit;
            if (commit) begin
                rf_dst  <= win_reg;
                rf_data <= win_data;
            end
        end
    end

endmodule
